// File: rtl/piso_defs.sv
// piso_defs: state encoding and counter sizing shared by the serializer and its receiver
package piso_defs;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, SHIFT = ST_SHIFT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bit_counter.sv
// bit_counter: frame bit index with synchronous clear and terminal-count flag at WIDTH-1
module bit_counter
  import piso_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = clog2(WIDTH);
  logic [CW-1:0] count;
  // advance once per enabled shift; clear wins so an idle block always restarts from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign tc = count == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: loads a parallel word on a valid/ready handshake and shifts it out one bit per enabled clock
module piso_serializer
  import piso_defs::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic tc, load, step, last;
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en (step && !tc),
    .tc (tc)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // handshake decode and next state; a stalled frame simply holds SHIFT
  always_comb begin
    load     = state == IDLE && load_valid;
    step     = state == SHIFT && en;
    last     = step && tc;
    state_nx = load ? SHIFT : last ? IDLE : state;
  end
  // sreg keeps the not-yet-sent bits so sout can stay registered; the first bit goes straight from data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sreg       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        sreg       <= advance(data);
        sout       <= first_bit(data);
        sout_valid <= 1'b1;
        frame      <= 1'b1;
      end else if (last) begin
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        frame      <= 1'b0;
      end else if (step) begin
        sreg  <= advance(sreg);
        sout  <= first_bit(sreg);
        frame <= 1'b0;
      end
    end
  assign load_ready = state == IDLE;
  assign busy       = state == SHIFT;
endmodule
